// File: rtl/dmme_pkg.sv
// Shared types for the DMME result collector.
// Lane width, word tags, FSM states and the queued word format.
package dmme_pkg;

    localparam int RES_W = 32;

    localparam logic TAG_12 = 1'b0;
    localparam logic TAG_22 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic               tag;
        logic [2*RES_W-1:0] data;
    } res_word_t;

endpackage

// File: rtl/dmme_result_collect_if.sv
// Ready/valid result stream toward the host/memory writer.
// master drives the word, slave drives ready.
interface dmme_result_collect_if;
    import dmme_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic [2*RES_W-1:0] out_data;
    logic               out_tag;

    modport master (
        output out_valid,
        output out_data,
        output out_tag,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_tag,
        output out_ready
    );

endinterface

// File: rtl/dmme_fifo_2w1r.sv
// Dual-push, single-pop first-word fall-through FIFO.
// wr_en[1] is only meaningful together with wr_en[0].
module dmme_fifo_2w1r
    import dmme_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [1:0]    wr_en,
    input  res_word_t     wr_data0,
    input  res_word_t     wr_data1,
    input  logic          rd_en,
    output logic          rd_valid,
    output res_word_t     rd_data,
    output logic [LW-1:0] level,
    output logic [LW-1:0] free
);

    res_word_t     mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] cnt;
    logic          pop;
    logic [1:0]    n_push;

    assign n_push   = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};
    assign rd_valid = (cnt != '0);
    assign pop      = rd_en && rd_valid;
    assign rd_data  = rd_valid ? mem[rptr] : '0;
    assign level    = cnt;
    assign free     = LW'(DEPTH) - cnt;

    // Storage: second push lands in the slot after the first.
    always_ff @(posedge clk) begin
        if (!clr) begin
            if (wr_en[0]) mem[wptr] <= wr_data0;
            if (wr_en[1]) mem[wptr + AW'(1)] <= wr_data1;
        end
    end

    // Pointers wrap modulo DEPTH; cnt carries the true occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            wptr <= wptr + AW'(n_push);
            rptr <= rptr + AW'(pop);
            cnt  <= cnt + LW'(n_push) - LW'(pop);
        end
    end

endmodule

// File: rtl/dmme_result_collect.sv
// Collects DMME result pairs into tagged words and streams them out.
// Tracks per-batch word count, drop overflow and end-of-batch drain.
module dmme_result_collect
    import dmme_pkg::*;
#(
    parameter  int DEPTH    = 8,
    parameter  int DATA_LAG = 1,
    parameter  int CNT_W    = 16,
    localparam int LW       = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  valid_12_in,
    input  logic                  valid_22_in,
    input  logic                  done_in,
    input  logic [RES_W-1:0]      cout_12_1,
    input  logic [RES_W-1:0]      cout_12_2,
    input  logic [RES_W-1:0]      cout_22_1,
    input  logic [RES_W-1:0]      cout_22_2,
    dmme_result_collect_if.master res_if,
    output logic [LW-1:0]         fifo_level,
    output logic [CNT_W-1:0]      word_count,
    output logic                  overflow,
    output logic                  batch_done
);

    logic          v12_s;
    logic          v22_s;
    logic          done_s;

    if (DATA_LAG == 1) begin : g_lag
        logic v12_q;
        logic v22_q;
        logic done_q;

        // Delay flags so they line up with the cout they qualify.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                {v12_q, v22_q, done_q} <= '0;
            end else if (clr) begin
                {v12_q, v22_q, done_q} <= '0;
            end else begin
                {v12_q, v22_q, done_q} <=
                    {valid_12_in, valid_22_in, done_in};
            end
        end

        assign v12_s  = v12_q;
        assign v22_s  = v22_q;
        assign done_s = done_q;
    end else begin : g_nolag
        assign v12_s  = valid_12_in;
        assign v22_s  = valid_22_in;
        assign done_s = done_in;
    end

    res_word_t     w12;
    res_word_t     w22;
    res_word_t     rd_word;
    logic          rd_valid;
    logic          pop;
    logic [LW-1:0] free_fifo;
    logic [LW-1:0] free_now;
    logic [LW-1:0] level_next;
    logic          acc12;
    logic          acc22;
    logic          drop;
    logic [1:0]    n_acc;
    logic [1:0]    wr_en;

    assign w12 = {TAG_12, cout_12_2, cout_12_1};
    assign w22 = {TAG_22, cout_22_2, cout_22_1};

    assign pop      = rd_valid && res_if.out_ready;
    // A same-cycle pop frees its slot for this cycle's push.
    assign free_now = free_fifo + LW'(pop);
    assign acc12    = v12_s && (free_now != '0);
    assign acc22    = v22_s && (free_now > LW'(acc12));
    assign drop     = (v12_s && !acc12) || (v22_s && !acc22);
    assign n_acc    = {1'b0, acc12} + {1'b0, acc22};
    assign wr_en    = {acc12 && acc22, acc12 || acc22};

    assign level_next = fifo_level + LW'(n_acc) - LW'(pop);

    dmme_fifo_2w1r #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_data0 (acc12 ? w12 : w22),
        .wr_data1 (w22),
        .rd_en    (pop),
        .rd_valid (rd_valid),
        .rd_data  (rd_word),
        .level    (fifo_level),
        .free     (free_fifo)
    );

    assign res_if.out_valid = rd_valid;
    assign res_if.out_data  = rd_word.data;
    assign res_if.out_tag   = rd_word.tag;

    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_sat;

    assign cnt_sum = {1'b0, word_count} + (CNT_W + 1)'(n_acc);
    assign cnt_sat = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

    state_t state_q;
    state_t state_d;
    logic   drain_end;

    // Next state and end-of-batch detection.
    always_comb begin
        state_d   = state_q;
        drain_end = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (n_acc != '0) begin
                    state_d = done_s ? ST_DRAIN : ST_COLLECT;
                end else if (done_s && fifo_level == '0) begin
                    drain_end = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (done_s) begin
                    if (level_next == '0) begin
                        drain_end = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (level_next == '0) begin
                    drain_end = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, batch pulse, saturating word counter, sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            batch_done <= 1'b0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else if (clr) begin
            state_q    <= ST_IDLE;
            batch_done <= 1'b0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            batch_done <= drain_end;
            word_count <= drain_end ? '0 : cnt_sat;
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmme_result_collect.sv
// Directed bench for dmme_result_collect (DEPTH=8, DATA_LAG=1).
// Inputs change and outputs are checked on the falling edge.
module tb_dmme_result_collect;
    import dmme_pkg::*;

    localparam int DEPTH = 8;
    localparam int LW    = 4;
    localparam int CNT_W = 16;

    logic              clk  = 1'b0;
    logic              rst  = 1'b0;
    logic              clr  = 1'b0;
    logic              v12  = 1'b0;
    logic              v22  = 1'b0;
    logic              done = 1'b0;
    logic [31:0]       c121 = '0;
    logic [31:0]       c122 = '0;
    logic [31:0]       c221 = '0;
    logic [31:0]       c222 = '0;
    logic [LW-1:0]     fifo_level;
    logic [CNT_W-1:0]  word_count;
    logic              overflow;
    logic              batch_done;
    logic [63:0]       e;

    int compared   = 0;
    int mismatched = 0;

    dmme_result_collect_if res_if ();

    dmme_result_collect #(
        .DEPTH    (DEPTH),
        .DATA_LAG (1),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .valid_12_in (v12),
        .valid_22_in (v22),
        .done_in     (done),
        .cout_12_1   (c121),
        .cout_12_2   (c122),
        .cout_22_1   (c221),
        .cout_22_2   (c222),
        .res_if      (res_if),
        .fifo_level  (fifo_level),
        .word_count  (word_count),
        .overflow    (overflow),
        .batch_done  (batch_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic all_zero(input string pfx);
        chk({pfx, "_valid"}, 64'(res_if.out_valid), 64'd0);
        chk({pfx, "_data"}, res_if.out_data, 64'd0);
        chk({pfx, "_tag"}, 64'(res_if.out_tag), 64'd0);
        chk({pfx, "_level"}, 64'(fifo_level), 64'd0);
        chk({pfx, "_count"}, 64'(word_count), 64'd0);
        chk({pfx, "_ovf"}, 64'(overflow), 64'd0);
        chk({pfx, "_bdone"}, 64'(batch_done), 64'd0);
    endtask

    initial begin
        res_if.out_ready = 1'b1;
        cyc(2);
        all_zero("rst");
        rst = 1'b1;
        cyc(1);

        // single 1x2 word, data arrives one cycle after the flag
        v12 = 1'b1; c121 = 32'hdead; c122 = 32'hbeef;
        cyc(1);
        v12 = 1'b0; c121 = 32'h11; c122 = 32'h22;
        chk("t1_lat1", 64'(res_if.out_valid), 64'd0);
        cyc(1);
        c121 = 32'h33; c122 = 32'h44;
        chk("t1_valid", 64'(res_if.out_valid), 64'd1);
        chk("t1_data", res_if.out_data, 64'h00000022_00000011);
        chk("t1_tag", 64'(res_if.out_tag), 64'd0);
        chk("t1_count", 64'(word_count), 64'd1);
        cyc(1);
        chk("t1_empty", 64'(res_if.out_valid), 64'd0);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        all_zero("clr1");

        // both pairs in one cycle
        v12 = 1'b1; v22 = 1'b1;
        c121 = 32'h1; c122 = 32'h2; c221 = 32'h3; c222 = 32'h4;
        cyc(1);
        v12 = 1'b0; v22 = 1'b0;
        c121 = 32'h5; c122 = 32'h6; c221 = 32'hA; c222 = 32'hB;
        cyc(1);
        c121 = '0; c122 = '0; c221 = '0; c222 = '0;
        chk("t2_d0", res_if.out_data, 64'h00000006_00000005);
        chk("t2_tag0", 64'(res_if.out_tag), 64'd0);
        chk("t2_level", 64'(fifo_level), 64'd2);
        chk("t2_count", 64'(word_count), 64'd2);
        cyc(1);
        chk("t2_d1", res_if.out_data, 64'h0000000B_0000000A);
        chk("t2_tag1", 64'(res_if.out_tag), 64'd1);
        chk("t2_level1", 64'(fifo_level), 64'd1);
        cyc(1);
        chk("t2_empty", 64'(res_if.out_valid), 64'd0);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;

        // ten words into eight slots with the consumer stalled
        res_if.out_ready = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            v12  = (i < 10);
            c121 = 32'h100 + i - 1;
            c122 = 32'h200 + i - 1;
            cyc(1);
        end
        chk("t3_level", 64'(fifo_level), 64'd8);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_count", 64'(word_count), 64'd8);
        res_if.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e = {32'h200 + 32'(k), 32'h100 + 32'(k)};
            chk($sformatf("t3_drain%0d", k), res_if.out_data, e);
            cyc(1);
        end
        chk("t3_empty", 64'(res_if.out_valid), 64'd0);
        chk("t3_level0", 64'(fifo_level), 64'd0);
        chk("t3_ovf_hold", 64'(overflow), 64'd1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("clr3_ovf", 64'(overflow), 64'd0);

        // three words, done, stalled drain
        res_if.out_ready = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            v12  = (i < 3);
            c121 = 32'h300 + i - 1;
            c122 = 32'h400 + i - 1;
            cyc(1);
        end
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        cyc(1);
        chk("t4_level", 64'(fifo_level), 64'd3);
        chk("t4_count", 64'(word_count), 64'd3);
        chk("t4_state", 64'(dut.state_q), 64'(ST_DRAIN));
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk($sformatf("t4_hold%0d", k), res_if.out_data,
                64'h00000400_00000300);
            chk($sformatf("t4_nobd%0d", k), 64'(batch_done), 64'd0);
        end
        res_if.out_ready = 1'b1;
        cyc(1);
        chk("t4_lvl2", 64'(fifo_level), 64'd2);
        chk("t4_bd_a", 64'(batch_done), 64'd0);
        cyc(1);
        chk("t4_lvl1", 64'(fifo_level), 64'd1);
        chk("t4_bd_b", 64'(batch_done), 64'd0);
        cyc(1);
        chk("t4_lvl0", 64'(fifo_level), 64'd0);
        chk("t4_bd_c", 64'(batch_done), 64'd1);
        chk("t4_cnt0", 64'(word_count), 64'd0);
        cyc(1);
        chk("t4_bd_d", 64'(batch_done), 64'd0);
        chk("t4_idle", 64'(dut.state_q), 64'(ST_IDLE));

        // done with nothing queued
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        chk("t5_bd_a", 64'(batch_done), 64'd0);
        cyc(1);
        chk("t5_bd_b", 64'(batch_done), 64'd1);
        chk("t5_cnt", 64'(word_count), 64'd0);
        cyc(1);
        chk("t5_bd_c", 64'(batch_done), 64'd0);

        // async reset while draining four words
        res_if.out_ready = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            v12  = (i < 4);
            c121 = 32'h500 + i - 1;
            c122 = 32'h600 + i - 1;
            cyc(1);
        end
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        cyc(1);
        chk("t6_level", 64'(fifo_level), 64'd4);
        chk("t6_state", 64'(dut.state_q), 64'(ST_DRAIN));
        rst = 1'b0;
        #1;
        all_zero("t6_rst");
        cyc(2);
        rst = 1'b1;
        res_if.out_ready = 1'b1;
        cyc(3);
        chk("t6_post_valid", 64'(res_if.out_valid), 64'd0);
        chk("t6_post_level", 64'(fifo_level), 64'd0);
        chk("t6_post_ovf", 64'(overflow), 64'd0);
        chk("t6_post_bd", 64'(batch_done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
